ej32_ifu: RTL and testbench
===========================

# ej32_ifu

Instruction fetch unit for the eJ32 core. It fetches 32-bit words from program memory into a small byte prefetch queue and presents one bytecode byte per cycle to the decoder unit. It advances on the decoder's `p_inc` and restarts the stream at a new address when the branch unit redirects. It is the producer for the decoder's `data` byte input.

## Interface

**Parameters**
- `ASZ`, default 17: byte address width.
- `QB`, default 8: prefetch queue depth in bytes. Must be a power of two and at least 8.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `p_inc`  in  1  decoder consumes the current byte this cycle.
- `br_ld`  in  1  redirect the byte stream to `br_addr`.
- `br_addr`  in  ASZ  redirect target byte address.
- `data`  out  8  current bytecode byte (queue head); 8'h00 (nop) when the queue is empty.
- `data_vld`  out  1  queue non-empty; `data` is meaningful.
- `pc`  out  ASZ  byte address of `data`.
- `mem_req`  out  1  word read request.
- `mem_addr`  out  ASZ  word-aligned read address; low 2 bits are always 0.
- `mem_ack`  in  1  read completes this cycle; `mem_rdata` is valid.
- `mem_rdata`  in  32  read word, big-endian: byte 0 is bits [31:24].

## Operation

**State**
- `pc`: consumer address.
- `fa`: next word fetch address.
- `skip` (2 bits): leading bytes to drop from the next accepted word.
- Queue: circular byte buffer with head and tail pointers and a count 0..QB.
- `inflt`: one request outstanding. At most one request is ever outstanding.
- `drop`: the outstanding response must be discarded.

**Request issue**
- Issue when `!mem_req`, `!br_ld`, and `QB - count >= 4`.
- On issue, `mem_req` goes to 1 with `mem_addr = fa`.
- `mem_req` and `mem_addr` stay stable until the cycle `mem_ack` = 1, then `mem_req` drops.
- A new request may issue the cycle after an ack.

**Response**
- On `mem_ack` with `drop` = 0: push bytes `skip..3` of `mem_rdata` in big-endian order, then `fa += 4` and `skip = 0`.
- On `mem_ack` with `drop` = 1: push nothing and clear `drop`.

**Consume**
- On `p_inc` && `data_vld`: pop the head byte and `pc += 1`.
- `p_inc` while the queue is empty is ignored; `pc` holds.

**Redirect (`br_ld`)**
- Queue is flushed (count = 0).
- `pc = br_addr`, `fa = {br_addr[ASZ-1:2], 2'b00}`, `skip = br_addr[1:0]`.
- If a request is in flight and not acked this cycle, set `drop` = 1. `mem_req` stays asserted, since the handshake is never abandoned.

**Simultaneous events**
- `br_ld` overrides `p_inc` and any same-cycle `mem_ack`; that ack's data is discarded.
- Push and pop in the same cycle: count changes by (pushed − 1).
- Address arithmetic wraps modulo 2^ASZ. Queue pointers wrap modulo QB.

## Timing

- **Reset values (`rst_n` low):** `pc` = 0, `fa` = 0, `skip` = 0, queue empty, `data_vld` = 0, `data` = 8'h00, `mem_req` = 0, `mem_addr` = 0, `drop` = 0.
- **Reset mid-request:** `mem_req` drops immediately; memory must tolerate this.
- **After reset release:** `mem_req` rises at the first edge.
- **Redirect latency (zero-wait memory, `mem_ack` in the same cycle as `mem_req`):** `br_ld` at edge T gives `mem_req` = 1 during cycle T+1, with the ack in that cycle. Bytes appear and `data_vld` = 1 in cycle T+2.
- **Steady state:** with zero-wait memory, `p_inc` every cycle never empties the queue once primed. Each 4-byte word takes 4 pops versus a 2-cycle refill.
- **Combinational outputs:** `data` and `data_vld` are combinational from registered queue state only; there is no input-to-output combinational path. `mem_req` and `mem_addr` are registered.

## Test plan

- **Reset and prime:** zero-wait memory, word at 0 = 32'h10_05_60_AC, no `p_inc`. `data_vld` rises on the 2nd cycle with `data` = 8'h10 and `pc` = 0. The queue fills to 8 and `mem_req` stays low.
- **Continuous consume:** `p_inc` held high with sequential words. `data` sequence matches memory byte order with `pc` incrementing by 1, and there are no gaps after priming.
- **Unaligned redirect:** `br_ld` with `br_addr` = 0x0006, word 0x0004 = 32'hAA_BB_CC_DD. Next valid `data` = 8'hCC with `pc` = 6, then 8'hDD with `pc` = 7, then byte 0 of word 0x0008.
- **Redirect during an in-flight request:** 3-cycle memory latency, `br_ld` to 0x0010 one cycle after `mem_req`. The stale word is dropped (`data` never shows it) and the first valid `data` is byte 0 of word 0x0010.
- **Simultaneous events:** `br_ld`, `p_inc` and `mem_ack` in the same cycle. Queue is empty the next cycle, `pc` = `br_addr`, and the acked data is discarded.
- **Empty stall and wrap:** `p_inc` asserted while empty leaves `pc` unchanged. Start at `br_addr` = 2^ASZ − 4 and consume: `pc` wraps to 0 and `mem_addr` wraps to 0.

Source files
------------

// File: rtl/ej32_ifu.sv
// eJ32 instruction fetch unit: fetches big-endian 32-bit words into a byte
// prefetch queue and hands the decoder one bytecode byte per cycle.
module ej32_ifu #(
  parameter int ASZ = 17,
  parameter int QB  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           p_inc,
  input  logic           br_ld,
  input  logic [ASZ-1:0] br_addr,
  output logic [7:0]     data,
  output logic           data_vld,
  output logic [ASZ-1:0] pc,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_addr,
  input  logic           mem_ack,
  input  logic [31:0]    mem_rdata
);

  localparam int PW = $clog2(QB);

  logic [7:0]     q_mem [QB];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PW:0]    count_q, count_d;
  logic [ASZ-1:0] pc_q, pc_d, fa_q, fa_d, addr_q, addr_d;
  logic [1:0]     skip_q, skip_d;
  logic           req_q, req_d, drop_q, drop_d;

  logic           pop, push;
  logic [2:0]     npush;
  logic [7:0]     push_byte [4];
  logic [3:0]     push_en;

  // req_q doubles as the in-flight flag: a request is outstanding exactly
  // while mem_req is held high.
  always_comb begin
    logic [1:0] sel;
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    skip_d  = skip_q;
    req_d   = req_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    sel     = '0;

    pop   = p_inc && (count_q != '0) && !br_ld;
    push  = req_q && mem_ack && !drop_q && !br_ld;
    npush = push ? (3'd4 - {1'b0, skip_q}) : 3'd0;

    for (int k = 0; k < 4; k++) begin
      sel          = skip_q + 2'(k);
      push_byte[k] = mem_rdata[8*(3-int'(sel)) +: 8];
      push_en[k]   = push && (3'(k) < npush);
    end

    if (br_ld) begin
      head_d  = tail_q;
      count_d = '0;
      pc_d    = br_addr;
      fa_d    = {br_addr[ASZ-1:2], 2'b00};
      skip_d  = br_addr[1:0];
      // A response still owed to the old stream must be thrown away.
      drop_d  = req_q && !mem_ack;
    end else begin
      if (pop) begin
        head_d = head_q + 1'b1;
        pc_d   = pc_q + 1'b1;
      end
      if (push) begin
        tail_d = tail_q + PW'(npush);
        fa_d   = fa_q + ASZ'(4);
        skip_d = 2'd0;
      end
      count_d = count_q + (PW+1)'(npush) - (PW+1)'(pop);
      if (req_q && mem_ack && drop_q) drop_d = 1'b0;
    end

    if (req_q && mem_ack) begin
      req_d = 1'b0;
    end else if (!req_q && !br_ld && ((PW+1)'(QB) - count_q >= (PW+1)'(4))) begin
      req_d  = 1'b1;
      addr_d = fa_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      fa_q    <= '0;
      skip_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      skip_q  <= skip_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates every read, so stale
  // bytes are never visible and the array can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_en[k]) q_mem[tail_q + PW'(k)] <= push_byte[k];
    end
  end

  assign data_vld = (count_q != '0);
  assign data     = data_vld ? q_mem[head_q] : 8'h00;
  assign pc       = pc_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_ej32_ifu.sv
// Self-checking bench for ej32_ifu: a memory responder with programmable
// latency, an address-based byte-stream reference model and a scoreboard.
module tb_ej32_ifu;
  localparam int ASZ = 17;
  localparam int QB  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           p_inc, br_ld;
  logic [ASZ-1:0] br_addr;
  logic [7:0]     data;
  logic           data_vld;
  logic [ASZ-1:0] pc;
  logic           mem_req;
  logic [ASZ-1:0] mem_addr;
  logic           mem_ack;
  logic [31:0]    mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ASZ-1:0] a;
    logic [7:0]     d;
  } exp_t;
  exp_t exp_q[$];

  ej32_ifu #(.ASZ(ASZ), .QB(QB)) dut (
    .clk(clk), .rst_n(rst_n), .p_inc(p_inc), .br_ld(br_ld), .br_addr(br_addr),
    .data(data), .data_vld(data_vld), .pc(pc), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Program memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [ASZ-1:0] a);
    logic [ASZ-1:0] w;
    w = {a[ASZ-1:2], 2'b00};
    if (w == ASZ'(0)) return 32'h10_05_60_AC;
    if (w == ASZ'(4)) return 32'hAA_BB_CC_DD;
    return {w[9:2] ^ 8'h5A, w[16:9] + 8'h33, ~w[7:0], w[15:8] ^ 8'hC3} ^ 32'h0102_0304;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [ASZ-1:0] a);
    logic [31:0] w;
    w = mem_word(a);
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after lat_cur wait cycles (0 = same cycle as request).
  int lat_cfg   = 0;
  bit rand_mode = 1'b0;
  int lat_cur;
  int wait_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      lat_cur  <= 0;
    end else begin
      wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
      if (!mem_req || mem_ack) lat_cur <= rand_mode ? int'($urandom_range(0, 3)) : lat_cfg;
    end
  end

  assign mem_ack   = mem_req && (wait_cnt >= lat_cur);
  assign mem_rdata = mem_word(mem_addr);

  // Monitor: pops the scoreboard on every consumed byte, plus protocol rules.
  logic           prev_pend = 1'b0;
  logic [ASZ-1:0] prev_addr;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!data_vld) check("idle_data", 32'(data), 32'h0);
      if (mem_req) check("addr_align", 32'(mem_addr[1:0]), 32'h0);
      if (p_inc && data_vld && !br_ld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: consumed pc %0h with no expectation", pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 32'(pc), 32'(e.a));
          check("sb_data", 32'(data), 32'(e.d));
        end
      end
      if (prev_pend) begin
        check("req_hold", 32'(mem_req), 32'h1);
        check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      end
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input logic [ASZ-1:0] a);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [ASZ-1:0] x;
      x = a + ASZ'(i);
      exp_q.push_back({x, mem_byte(x)});
    end
  endtask

  task automatic redirect(input logic [ASZ-1:0] a);
    expect_stream(a);
    br_addr = a;
    br_ld   = 1'b1;
    cyc();
    br_ld   = 1'b0;
  endtask

  task automatic wait_vld(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (data_vld) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  initial begin
    bit ok;
    bit saw_zero;
    int since;
    rst_n   = 1'b0;
    p_inc   = 1'b0;
    br_ld   = 1'b0;
    br_addr = '0;
    repeat (3) cyc();

    check("rst_pc", 32'(pc), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_vld", 32'(data_vld), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);

    // Reset and prime with zero-wait memory.
    expect_stream('0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("prime_req", 32'(mem_req), 32'h1);
    check("prime_vld0", 32'(data_vld), 32'h0);
    cyc();
    check("prime_vld", 32'(data_vld), 32'h1);
    check("prime_data", 32'(data), 32'h10);
    check("prime_pc", 32'(pc), 32'h0);
    repeat (2) cyc();
    for (int i = 0; i < 6; i++) begin
      check("full_idle", 32'(mem_req), 32'h0);
      check("full_head", 32'(data), 32'h10);
      cyc();
    end

    // Continuous consume: no gaps once primed.
    p_inc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      check("no_gap", 32'(data_vld), 32'h1);
    end

    // Unaligned redirect into word 0x0004.
    redirect(ASZ'(6));
    wait_vld(10, ok);
    check("unal_seen", 32'(ok), 32'h1);
    check("unal_pc0", 32'(pc), 32'h6);
    check("unal_d0", 32'(data), 32'hCC);
    cyc();
    check("unal_pc1", 32'(pc), 32'h7);
    check("unal_d1", 32'(data), 32'hDD);
    cyc();
    check("unal_pc2", 32'(pc), 32'h8);
    check("unal_d2", 32'(data), 32'(mem_byte(ASZ'(8))));

    // Redirect while a slow request is in flight; empty-queue p_inc must stall.
    lat_cfg = 3;
    cyc();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && lat_cur == 3) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check("slow_req_seen", 32'(ok), 32'h1);
    cyc();
    check("inflight", 32'(mem_req), 32'h1);
    redirect(ASZ'('h10));
    check("stall_pc0", 32'(pc), 32'h10);
    check("stall_vld0", 32'(data_vld), 32'h0);
    cyc();
    check("stall_pc1", 32'(pc), 32'h10);
    check("stall_vld1", 32'(data_vld), 32'h0);
    wait_vld(30, ok);
    check("drop_seen", 32'(ok), 32'h1);
    check("drop_pc", 32'(pc), 32'h10);
    check("drop_data", 32'(data), 32'(mem_byte(ASZ'('h10))));

    // br_ld, p_inc and mem_ack all in the same cycle.
    lat_cfg = 0;
    cyc();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && mem_ack && data_vld) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check("simul_setup", 32'(ok), 32'h1);
    redirect(ASZ'('h123));
    check("simul_vld", 32'(data_vld), 32'h0);
    check("simul_pc", 32'(pc), 32'h123);
    wait_vld(10, ok);
    check("simul_seen", 32'(ok), 32'h1);
    check("simul_pc2", 32'(pc), 32'h123);
    check("simul_data", 32'(data), 32'(mem_byte(ASZ'('h123))));

    // Address wrap at the top of the byte space.
    redirect(ASZ'((1 << ASZ) - 4));
    saw_zero = 1'b0;
    ok       = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && mem_addr == '0) saw_zero = 1'b1;
      if (data_vld && pc == '0) ok = 1'b1;
      cyc();
    end
    check("wrap_memaddr", 32'(saw_zero), 32'h1);
    check("wrap_pc", 32'(ok), 32'h1);

    // Randomized traffic: random latency, random p_inc, random redirects.
    rand_mode = 1'b1;
    since     = 0;
    for (int i = 0; i < 1500; i++) begin
      p_inc = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0 || since >= 200) begin
        redirect(ASZ'($urandom_range(0, (1 << ASZ) - 1)));
        since = 0;
      end else begin
        cyc();
        since++;
      end
    end

    p_inc     = 1'b0;
    rand_mode = 1'b0;
    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
